uart_apb_master: RTL

UART_APB_MASTER -- requirements
Module: uart_apb_master

---
 rtl/uart_apb_master.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_apb_master.sv
// APB master that configures a UART core, then polls its STATUS register and
// moves received bytes to an rx stream and tx-stream bytes into the transmitter.
module uart_apb_master #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  CTRL2_BITS = 3'b001,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       cfg_done
);

  typedef enum logic [2:0] {CFG1, CFG2, GAP, POLL, RD_RX, WR_TX} state_t;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [7:0] GAP_LAST   = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  // With no gap configured, every transfer is followed straight by a status poll.
  localparam state_t     AFTER_XFER = (POLL_GAP == 0) ? POLL : GAP;

  state_t     state, next_state;
  logic [7:0] gap_cnt;
  logic       xfer_done;
  logic       poll_done;
  logic [3:0] err_set;
  logic       start_xfer;
  logic [4:0] setup_addr;
  logic       setup_write;
  logic [7:0] setup_wdata;

  assign xfer_done = PSEL & PENABLE & PREADY;
  assign poll_done = xfer_done & (state == POLL);
  assign tx_ready  = xfer_done & (state == WR_TX);
  assign err_set   = {xfer_done & PSLVERR, {3{poll_done}} & PRDATA[4:2]};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement leaves a latch behind.
  always_comb begin
    next_state = state;
    unique case (state)
      CFG1:    if (xfer_done) next_state = CFG2;
      CFG2:    if (xfer_done) next_state = AFTER_XFER;
      GAP:     if (gap_cnt == GAP_LAST) next_state = POLL;
      POLL: begin
        if (xfer_done) begin
          if (PRDATA[1] && !rx_valid)     next_state = RD_RX;
          else if (PRDATA[0] && tx_valid) next_state = WR_TX;
          else                            next_state = AFTER_XFER;
        end
      end
      RD_RX, WR_TX: if (xfer_done) next_state = AFTER_XFER;
      default: next_state = CFG1;
    endcase
  end

  // Address/direction/data for the transfer that the next state will issue.
  always_comb begin
    start_xfer  = 1'b1;
    setup_addr  = ADDR_STATUS;
    setup_write = 1'b0;
    setup_wdata = 8'h00;
    unique case (next_state)
      CFG1: begin
        setup_addr  = ADDR_CTRL1;
        setup_write = 1'b1;
        setup_wdata = BAUD_VALUE[7:0];
      end
      CFG2: begin
        setup_addr  = ADDR_CTRL2;
        setup_write = 1'b1;
        setup_wdata = {BAUD_VALUE[12:8], CTRL2_BITS};
      end
      POLL:  setup_addr = ADDR_STATUS;
      RD_RX: setup_addr = ADDR_RXDATA;
      WR_TX: begin
        setup_addr  = ADDR_TXDATA;
        setup_write = 1'b1;
        setup_wdata = tx_data;
      end
      default: start_xfer = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state   <= CFG1;
      gap_cnt <= 8'd0;
    end else begin
      state   <= next_state;
      gap_cnt <= (state == GAP && next_state == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 5'h00;
      PWDATA  <= 8'h00;
    end else if (PSEL && !xfer_done) begin
      PENABLE <= 1'b1;
    end else if (start_xfer) begin
      PSEL    <= 1'b1;
      PENABLE <= 1'b0;
      PADDR   <= setup_addr;
      PWRITE  <= setup_write;
      PWDATA  <= setup_wdata;
    end else begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      cfg_done  <= 1'b0;
      err_flags <= 4'h0;
    end else begin
      // A slave error still completes the read, so the byte is delivered.
      if (xfer_done && state == RD_RX) begin
        rx_data  <= PRDATA;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (xfer_done && state == CFG2) cfg_done <= 1'b1;
      err_flags <= err_clr ? err_set : (err_flags | err_set);
    end
  end

endmodule
